// File: rtl/hes_pkg.sv
// Shared definitions for the HES stream-cipher blocks.
//   BYTE_W : width of one cipher lane (one byte)
//   byte_t : one lane's data, key or counter byte
package hes_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef logic [BYTE_W-1:0] byte_t;

endpackage

// File: rtl/hes_ctr_stream_lanes_if.sv
// Bus between a byte/word source, the lane-parallel HES counter-mode cipher and the output
// framer.
//   upstream   : in_valid, in_ready, new_message, key, iv, data_in
//   downstream : out_valid, out_ready, data_out, ctr_out, ctr_wrap
// master = source/sink side (drives beats, accepts results); slave = the cipher.
interface hes_ctr_stream_lanes_if #(
  parameter int unsigned LANES = 1,
  parameter int unsigned CTR_W = 8
);
  import hes_pkg::*;

  logic                      in_valid;
  logic                      in_ready;
  logic                      new_message;
  logic [BYTE_W*LANES-1:0]   key;
  logic [CTR_W-1:0]          iv;
  logic [BYTE_W*LANES-1:0]   data_in;
  logic                      out_valid;
  logic                      out_ready;
  logic [BYTE_W*LANES-1:0]   data_out;
  logic [CTR_W-1:0]          ctr_out;
  logic                      ctr_wrap;

  modport master (
    output in_valid, new_message, key, iv, data_in, out_ready,
    input  in_ready, out_valid, data_out, ctr_out, ctr_wrap
  );

  modport slave (
    input  in_valid, new_message, key, iv, data_in, out_ready,
    output in_ready, out_valid, data_out, ctr_out, ctr_wrap
  );

endinterface

// File: rtl/hes_sbox.sv
// Combinational AES S-box: one byte in, its substitution out.
//   val : byte to substitute
//   sub : SBOX(val)
module hes_sbox
  import hes_pkg::*;
(
  input  byte_t val,
  output byte_t sub
);

  localparam byte_t SBOX_TABLE [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
    8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
    8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
    8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
    8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
    8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
    8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
    8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
    8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
    8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
    8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
    8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
    8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
    8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
    8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
    8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
    8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign sub = SBOX_TABLE[val];

endmodule

// File: rtl/hes_ctr_stream_lanes.sv
// Lane-parallel HES counter-mode stream cipher.
// Each beat carries LANES bytes; lane i is XORed with SBOX(key_q[i] ^ (c+i)[7:0]), where c is
// the beat's base counter. Two-stage pipeline (S1: data/counter/key-mix, S2: S-box, XOR and
// output registers) with valid/ready flow control on both sides.
//   clk, reset_n : clock; asynchronous reset, asserted when reset_n = 1
//   bus (slave)  : in_valid/in_ready/new_message/key/iv/data_in from the source,
//                  out_valid/out_ready/data_out/ctr_out/ctr_wrap to the framer
module hes_ctr_stream_lanes
  import hes_pkg::*;
#(
  parameter int unsigned LANES = 1,
  parameter int unsigned CTR_W = 8
) (
  input logic                  clk,
  input logic                  reset_n,
  hes_ctr_stream_lanes_if.slave bus
);

  localparam int unsigned DATA_W = BYTE_W * LANES;

  logic              en;
  logic              accept;
  logic              idle_load;
  logic [CTR_W-1:0]  base_ctr;
  logic [CTR_W:0]    ctr_sum;
  logic [DATA_W-1:0] key_eff;
  logic [DATA_W-1:0] kx_d;
  logic [DATA_W-1:0] keystream;

  // Message state
  logic [CTR_W-1:0]  ctr_q;
  logic [DATA_W-1:0] key_q;

  // Stage 1
  logic              s1_valid_q;
  logic [DATA_W-1:0] s1_data_q;
  logic [DATA_W-1:0] s1_kx_q;
  logic [CTR_W-1:0]  s1_ctr_q;
  logic              s1_wrap_q;

  // Stage 2 / outputs
  logic              out_valid_q;
  logic [DATA_W-1:0] data_out_q;
  logic [CTR_W-1:0]  ctr_out_q;
  logic              ctr_wrap_q;

  // The whole pipeline advances whenever the output slot is free or being drained.
  assign en           = !out_valid_q || bus.out_ready;
  assign bus.in_ready = en && !reset_n;
  assign accept       = bus.in_valid && bus.in_ready;

  // new_message with no beat offered only reloads IV/key. If a beat is offered but stalled,
  // nothing happens until it is accepted.
  assign idle_load = bus.new_message && !bus.in_valid;

  // A beat that opens a message uses iv/key directly, not the stale registered values.
  assign base_ctr = bus.new_message ? bus.iv  : ctr_q;
  assign key_eff  = bus.new_message ? bus.key : key_q;

  // Extra top bit is the carry out of the beat's counter range, i.e. the wrap flag.
  assign ctr_sum = {1'b0, base_ctr} + (CTR_W+1)'(LANES);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    byte_t lane_ctr_byte;

    // Only the low byte of c+i feeds the keystream; the low byte of a sum depends only on the
    // low bytes of its operands.
    assign lane_ctr_byte = base_ctr[BYTE_W-1:0] + BYTE_W'(i);
    assign kx_d[i*BYTE_W +: BYTE_W] = key_eff[i*BYTE_W +: BYTE_W] ^ lane_ctr_byte;

    hes_sbox u_sbox (
      .val (s1_kx_q[i*BYTE_W +: BYTE_W]),
      .sub (keystream[i*BYTE_W +: BYTE_W])
    );
  end

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      ctr_q       <= '0;
      key_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_kx_q     <= '0;
      s1_ctr_q    <= '0;
      s1_wrap_q   <= 1'b0;
      out_valid_q <= 1'b0;
      data_out_q  <= '0;
      ctr_out_q   <= '0;
      ctr_wrap_q  <= 1'b0;
    end else begin
      if (accept) begin
        ctr_q <= ctr_sum[CTR_W-1:0];
        if (bus.new_message) begin
          key_q <= bus.key;
        end
      end else if (idle_load) begin
        ctr_q <= bus.iv;
        key_q <= bus.key;
      end

      if (en) begin
        s1_valid_q <= accept;
        if (accept) begin
          s1_data_q <= bus.data_in;
          s1_kx_q   <= kx_d;
          s1_ctr_q  <= base_ctr;
          s1_wrap_q <= ctr_sum[CTR_W];
        end

        out_valid_q <= s1_valid_q;
        // Bubbles leave the last result in place so the outputs only move on a real beat.
        if (s1_valid_q) begin
          data_out_q <= s1_data_q ^ keystream;
          ctr_out_q  <= s1_ctr_q;
          ctr_wrap_q <= s1_wrap_q;
        end
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.data_out  = data_out_q;
  assign bus.ctr_out   = ctr_out_q;
  assign bus.ctr_wrap  = ctr_wrap_q;

endmodule

// File: tb/tb_hes_ctr_stream_lanes.sv
// Bench for hes_ctr_stream_lanes: a LANES=1/CTR_W=8 and a LANES=2/CTR_W=12 instance share one
// stimulus stream. A queue-based reference model predicts every output beat.
module tb_hes_ctr_stream_lanes;
  import hes_pkg::*;

  typedef struct packed {
    logic [15:0] data;
    logic [11:0] ctr;
    logic        wrap;
  } beat_t;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        new_message;
  logic        out_ready;
  logic [15:0] key_s;
  logic [11:0] iv_s;
  logic [15:0] data_s;
  int          ready_mode;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  sbox_tb [256];
  beat_t       q_a[$], q_b[$], seq_a[$], seq_b[$];
  int unsigned m_ctr_a, m_ctr_b;
  logic [15:0] m_key_a, m_key_b;
  logic [15:0] ka, kb;
  int unsigned ca, cb;

  hes_ctr_stream_lanes_if #(.LANES(1), .CTR_W(8))  if_a ();
  hes_ctr_stream_lanes_if #(.LANES(2), .CTR_W(12)) if_b ();

  assign if_a.in_valid    = in_valid;
  assign if_a.new_message = new_message;
  assign if_a.key         = key_s[7:0];
  assign if_a.iv          = iv_s[7:0];
  assign if_a.data_in     = data_s[7:0];
  assign if_a.out_ready   = out_ready;
  assign if_b.in_valid    = in_valid;
  assign if_b.new_message = new_message;
  assign if_b.key         = key_s;
  assign if_b.iv          = iv_s;
  assign if_b.data_in     = data_s;
  assign if_b.out_ready   = out_ready;

  hes_ctr_stream_lanes #(.LANES(1), .CTR_W(8)) u_dut_a (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (if_a.slave)
  );

  hes_ctr_stream_lanes #(.LANES(2), .CTR_W(12)) u_dut_b (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (if_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // GF(2^8) arithmetic for building the S-box from its definition.
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    logic       hi;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = a << 1;
      if (hi) a = a ^ 8'h1b;
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic beat_t model_beat(input int unsigned lanes, input int unsigned ctrw,
                                       input logic [15:0] k, input int unsigned c,
                                       input logic [15:0] d);
    beat_t       r;
    int unsigned modv;
    logic [7:0]  cbyte;
    modv   = 32'd1 << ctrw;
    r      = '0;
    r.ctr  = 12'(c);
    r.wrap = ((c + lanes) >= modv);
    for (int unsigned i = 0; i < lanes; i++) begin
      cbyte = 8'((c + i) % modv);
      r.data[8*i +: 8] = d[8*i +: 8] ^ sbox_tb[k[8*i +: 8] ^ cbyte];
    end
    return r;
  endfunction

  // Reference model and output scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    if (reset_n) begin
      q_a.delete();
      q_b.delete();
      m_ctr_a = 0; m_ctr_b = 0; m_key_a = '0; m_key_b = '0;
      check_val("in_ready_rst", 32'(if_a.in_ready), 32'd0);
    end else begin
      check_val("in_ready_a", 32'(if_a.in_ready), 32'(!if_a.out_valid || out_ready));
      check_val("in_ready_b", 32'(if_b.in_ready), 32'(!if_b.out_valid || out_ready));

      if (if_a.out_valid) begin
        if (q_a.size() == 0) check_val("spurious_a", 32'd1, 32'd0);
        else begin
          check_val("data_a", 32'(if_a.data_out), 32'(q_a[0].data));
          check_val("ctr_a", 32'(if_a.ctr_out), 32'(q_a[0].ctr));
          check_val("wrap_a", 32'(if_a.ctr_wrap), 32'(q_a[0].wrap));
          if (out_ready) begin
            seq_a.push_back('{data: 16'(if_a.data_out), ctr: 12'(if_a.ctr_out),
                              wrap: if_a.ctr_wrap});
            void'(q_a.pop_front());
          end
        end
      end
      if (if_b.out_valid) begin
        if (q_b.size() == 0) check_val("spurious_b", 32'd1, 32'd0);
        else begin
          check_val("data_b", 32'(if_b.data_out), 32'(q_b[0].data));
          check_val("ctr_b", 32'(if_b.ctr_out), 32'(q_b[0].ctr));
          check_val("wrap_b", 32'(if_b.ctr_wrap), 32'(q_b[0].wrap));
          if (out_ready) begin
            seq_b.push_back('{data: if_b.data_out, ctr: if_b.ctr_out, wrap: if_b.ctr_wrap});
            void'(q_b.pop_front());
          end
        end
      end

      if (in_valid && if_a.in_ready) begin
        ka = new_message ? {8'h00, key_s[7:0]} : m_key_a;
        ca = new_message ? 32'(iv_s[7:0]) : m_ctr_a;
        q_a.push_back(model_beat(1, 8, ka, ca, {8'h00, data_s[7:0]}));
        m_key_a = ka;
        m_ctr_a = (ca + 1) % 256;
      end else if (new_message && !in_valid) begin
        m_key_a = {8'h00, key_s[7:0]};
        m_ctr_a = 32'(iv_s[7:0]);
      end

      if (in_valid && if_b.in_ready) begin
        kb = new_message ? key_s : m_key_b;
        cb = new_message ? 32'(iv_s) : m_ctr_b;
        q_b.push_back(model_beat(2, 12, kb, cb, data_s));
        m_key_b = kb;
        m_ctr_b = (cb + 2) % 4096;
      end else if (new_message && !in_valid) begin
        m_key_b = key_s;
        m_ctr_b = 32'(iv_s);
      end
    end
  end

  // Downstream ready pattern: 0 = always ready, 1 = random, 2 = stalled.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = 1'b0;
      endcase
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive_beat(input logic nm, input logic [15:0] k, input logic [11:0] v,
                            input logic [15:0] d);
    int   n;
    logic acc;
    n = 0;
    in_valid = 1'b1; new_message = nm; key_s = k; iv_s = v; data_s = d;
    do begin
      @(negedge clk);
      acc = if_a.in_ready;
      @(posedge clk); #1;
      n++;
    end while (!acc && n < 200);
    if (!acc) check_val("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
    new_message = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((q_a.size() != 0 || q_b.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_val("drain", 32'(q_a.size() + q_b.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic chk_seq(input string tag, input bit lane_a, input int idx,
                         input logic [15:0] d, input logic [11:0] c, input logic w);
    beat_t b;
    int    sz;
    sz = lane_a ? seq_a.size() : seq_b.size();
    if (idx < sz) begin
      b = lane_a ? seq_a[idx] : seq_b[idx];
      check_val({tag, "_data"}, 32'(b.data), 32'(d));
      check_val({tag, "_ctr"}, 32'(b.ctr), 32'(c));
      check_val({tag, "_wrap"}, 32'(b.wrap), 32'(w));
    end else begin
      check_val({tag, "_missing"}, 32'(sz), 32'(idx + 1));
    end
  endtask

  initial begin
    logic [7:0] inv, s;
    int         r;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sbox_tb[x] = s;
    end

    ready_mode = 0;
    in_valid = 1'b0; new_message = 1'b0; key_s = '0; iv_s = '0; data_s = '0;
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check_val("rst_out_valid_a", 32'(if_a.out_valid), 32'd0);
    check_val("rst_data_a", 32'(if_a.data_out), 32'd0);
    check_val("rst_ctr_a", 32'(if_a.ctr_out), 32'd0);
    check_val("rst_wrap_a", 32'(if_a.ctr_wrap), 32'd0);
    check_val("rst_out_valid_b", 32'(if_b.out_valid), 32'd0);
    check_val("rst_in_ready_b", 32'(if_b.in_ready), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b0;
    repeat (2) @(posedge clk); #1;

    // Known-answer stream with key 0x11 per lane, iv 0; also checks the two-cycle latency.
    seq_a.delete(); seq_b.delete();
    drive_beat(1'b1, 16'h1111, 12'h000, 16'h0000);
    @(negedge clk);
    check_val("lat_early_a", 32'(if_a.out_valid), 32'd0);
    @(negedge clk);
    check_val("lat_a", 32'(if_a.out_valid), 32'd1);
    check_val("lat_b", 32'(if_b.out_valid), 32'd1);
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) drive_beat(1'b0, 16'h1111, 12'h000, 16'h0000);
    wait_drain();
    chk_seq("kat_a0", 1'b1, 0, 16'h0082, 12'h000, 1'b0);
    chk_seq("kat_a1", 1'b1, 1, 16'h00ca, 12'h001, 1'b0);
    chk_seq("kat_a2", 1'b1, 2, 16'h007d, 12'h002, 1'b0);
    chk_seq("kat_a3", 1'b1, 3, 16'h00c9, 12'h003, 1'b0);
    chk_seq("kat_b0", 1'b0, 0, 16'hca82, 12'h000, 1'b0);
    chk_seq("kat_b1", 1'b0, 1, 16'hc97d, 12'h002, 1'b0);

    // Counter wrap at the top of the range, including a wrap inside a two-lane beat.
    seq_a.delete(); seq_b.delete();
    drive_beat(1'b1, 16'h0000, 12'hfff, 16'h0000);
    drive_beat(1'b0, 16'h0000, 12'h000, 16'h0000);
    wait_drain();
    chk_seq("wrap_a0", 1'b1, 0, 16'h0016, 12'h0ff, 1'b1);
    chk_seq("wrap_a1", 1'b1, 1, 16'h0063, 12'h000, 1'b0);
    chk_seq("wrap_b0", 1'b0, 0, 16'h6316, 12'hfff, 1'b1);
    chk_seq("wrap_b1", 1'b0, 1, 16'h777c, 12'h001, 1'b0);

    // Backpressure: downstream stalled while beats keep arriving.
    ready_mode = 2;
    repeat (2) @(posedge clk); #1;
    seq_a.delete(); seq_b.delete();
    fork
      begin
        drive_beat(1'b1, 16'h1111, 12'h000, 16'h0000);
        drive_beat(1'b0, 16'h1111, 12'h000, 16'h0000);
        drive_beat(1'b0, 16'h1111, 12'h000, 16'h0000);
      end
      begin
        repeat (6) @(negedge clk);
        check_val("stall_in_ready", 32'(if_a.in_ready), 32'd0);
        check_val("stall_out_valid", 32'(if_a.out_valid), 32'd1);
        check_val("stall_data", 32'(if_a.data_out), 32'h82);
        ready_mode = 0;
      end
    join
    wait_drain();
    check_val("bp_count", 32'(seq_a.size()), 32'd3);
    chk_seq("bp_a0", 1'b1, 0, 16'h0082, 12'h000, 1'b0);
    chk_seq("bp_a1", 1'b1, 1, 16'h00ca, 12'h001, 1'b0);
    chk_seq("bp_a2", 1'b1, 2, 16'h007d, 12'h002, 1'b0);

    // Re-key mid-stream.
    seq_a.delete(); seq_b.delete();
    drive_beat(1'b1, 16'h1111, 12'h000, 16'h0000);
    drive_beat(1'b0, 16'h1111, 12'h000, 16'h0000);
    drive_beat(1'b1, 16'h0000, 12'h000, 16'h0001);
    wait_drain();
    chk_seq("rekey_a", 1'b1, 2, 16'h0062, 12'h000, 1'b0);
    chk_seq("rekey_b", 1'b0, 2, 16'h7c62, 12'h000, 1'b0);

    // Random traffic against the reference model.
    ready_mode = 1;
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        new_message = 1'b1; key_s = 16'($urandom); iv_s = 12'($urandom);
        @(posedge clk); #1;
        new_message = 1'b0;
      end else if (r == 1) begin
        @(posedge clk); #1;
      end else begin
        drive_beat(($urandom_range(0, 7) == 0), 16'($urandom), 12'($urandom),
                   16'($urandom));
      end
    end
    ready_mode = 0;
    wait_drain();

    // Asynchronous reset with beats in flight.
    drive_beat(1'b1, 16'h1111, 12'h000, 16'h0000);
    drive_beat(1'b0, 16'h1111, 12'h000, 16'h0000);
    reset_n = 1'b1;
    #1;
    check_val("async_rst_valid_a", 32'(if_a.out_valid), 32'd0);
    check_val("async_rst_valid_b", 32'(if_b.out_valid), 32'd0);
    check_val("async_rst_data_a", 32'(if_a.data_out), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b0;
    seq_a.delete(); seq_b.delete();
    drive_beat(1'b0, 16'h1111, 12'h055, 16'h0000);
    wait_drain();
    check_val("post_rst_count", 32'(seq_a.size()), 32'd1);
    chk_seq("post_rst_a", 1'b1, 0, 16'h0063, 12'h000, 1'b0);
    chk_seq("post_rst_b", 1'b0, 0, 16'h7c63, 12'h000, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/hes_ctr_stream_lanes.md
Name: hes_ctr_stream_lanes

Overview:
- Parametrised successor of the byte-wide HES counter-mode stream cipher.
- Encrypts LANES bytes per beat: data XOR keystream, where each keystream byte = SBOX(key byte XOR counter byte).
- Adds valid/ready backpressure on both sides, a programmable IV, multi-lane counters, and a counter-wrap indication.
- Sits between the byte/word source and the HES output framer.

Parameters:
- LANES, 1: bytes processed per beat; data width is 8*LANES.
- CTR_W, 8: counter width in bits (8..32). Keystream uses counter bits [7:0].

Ports:
- clk  input  1  clock
- reset_n  input  1  reset, asynchronous, active-high (asserted when 1)
- in_valid  input  1  input beat valid
- in_ready  output  1  block can accept a beat
- new_message  input  1  start of message; loads IV and latches key
- key  input  8*LANES  per-lane key bytes, lane i = bits [8i+7:8i]
- iv  input  CTR_W  initial counter value for the message
- data_in  input  8*LANES  plaintext/ciphertext beat
- out_valid  output  1  output beat valid
- out_ready  input  1  downstream accepts the beat
- data_out  output  8*LANES  data_in XOR keystream
- ctr_out  output  CTR_W  lane-0 counter used for this beat
- ctr_wrap  output  1  beat's counter range crossed 2^CTR_W

Behaviour:
- Reset (reset_n=1):
  - out_valid=0, data_out=0, ctr_out=0, ctr_wrap=0.
  - Internal ctr=0, key_q=0, both pipeline stages empty.
  - In-flight beats are discarded. in_ready=0 during reset.
- Pipeline:
  - Two stages. S1 registers data, ctr, and key_q XOR ctr-bytes. S2 applies SBOX, XORs with data, and drives the outputs.
  - Latency is 2 cycles from accept to out_valid, with no stall.
- Handshake:
  - en = !out_valid || out_ready; in_ready = en.
  - A beat is accepted when in_valid && in_ready.
  - When en=0, both stages hold. Output data, ctr_out and ctr_wrap must be stable while out_valid && !out_ready.
  - Bubbles advance normally.
- Lane counters:
  - Lane i of a beat uses counter c+i (mod 2^CTR_W), where c is the beat's base counter.
  - Keystream byte i = SBOX(key_q[i] XOR (c+i)[7:0]).
  - After each accepted beat, ctr <= c+LANES (mod 2^CTR_W).
- new_message:
  - With an accepted beat: that beat uses c=iv and key_q=key (bypass, same cycle); then key_q<=key and ctr<=iv+LANES.
  - Without an accepted beat: key_q<=key and ctr<=iv. No output is produced.
  - Asserted with in_valid while in_ready=0: no effect. The source must hold it until the beat is accepted.
- ctr_wrap: 1 for the beat whose lanes c..c+LANES-1 include the value 2^CTR_W-1 followed by a wrap to 0. Computed as c+LANES > 2^CTR_W-1 in CTR_W+1-bit arithmetic. Wrap is legal and not an error.
- Simultaneous accept and output drain in the same cycle: full throughput of 1 beat per cycle.
- Changes to key mid-message without new_message are ignored (key_q is used).

Decomposition:
- Shared package hes_pkg: BYTE_W=8 and the typedef byte_t.
- Sub-module hes_sbox: combinational 8-bit AES S-box, instantiated LANES times in S2.
- Everything else stays in one module.

Test Plan:
- LANES=1, key=0x11, iv=0x00, new_message with beat 0, data 0x00,0x00,0x00,0x00 -> data_out 0x82,0xCA,0x7D,0xC9; ctr_out 0,1,2,3; first out_valid 2 cycles after accept.
- LANES=1, key=0x00, iv=0xFF, data 0x00,0x00 -> data_out 0x16 (ctr_wrap=1, ctr_out=0xFF), then 0x63 (ctr_wrap=0, ctr_out=0x00).
- LANES=2, key=0x1111, iv=0x00, data 0x0000 twice -> data_out 0xCA82 then 0xC97D; ctr_out 0 then 2.
- Backpressure, LANES=1, key=0x11, iv=0x00:
  - Stimulus: hold out_ready=0 for 5 cycles while in_valid=1 is streamed.
  - Check: in_ready drops once out_valid=1; data_out stays 0x82; no beats are lost or duplicated after release (sequence 0x82,0xCA,0x7D).
- Re-key mid-stream: after 2 beats, apply new_message with key=0x00, iv=0x00 and data 0x01 -> data_out 0x62 (0x63^0x01), ctr_out 0.
- Reset mid-operation: assert reset_n with 2 beats in flight -> out_valid=0 immediately (async); after release, the first beat without new_message uses ctr=0, key 0 -> data_out 0x63 for data 0x00.
